out_pattern_gen: RTL

- Programmable periodic/one-shot pulse-train generator: out is high for N_REG clocks, then low for M_REG clocks.
- Periodic mode repeats the pattern until stopped; one-shot mode runs it once and flags done.
- Parametrised successor of the fixed "N clocks high, 1 clock low" generator; used as a timing/strobe source by neighbouring datapath blocks.
- With AUTO_START=1 and defaults, it reproduces the legacy waveform (3 high, 1 low, repeating) directly from reset.

---
 rtl/out_pattern_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/out_pattern_gen.sv
// Programmable pulse-train generator: out high for N_REG clocks, low for M_REG clocks,
// periodic or one-shot, with deferred stop and load-at-next-phase semantics.
`timescale 1ns/1ps
module out_pattern_gen #(
   parameter int unsigned W          = 4,
   parameter int unsigned N_DEF      = 3,
   parameter int unsigned M_DEF      = 1,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         mode,
   input  logic         stop,
   input  logic         load,
   input  logic [W-1:0] n_in,
   input  logic [W-1:0] m_in,
   output logic         out,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   localparam logic [W-1:0] ONE = W'(1);

   state_t       state;
   logic [W-1:0] count;
   logic [W-1:0] n_reg;
   logic [W-1:0] m_reg;
   logic         stop_pend;
   logic         start_pend;
   logic         mode_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         out        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         count      <= '0;
         n_reg      <= W'(N_DEF);
         m_reg      <= W'(M_DEF);
         stop_pend  <= 1'b0;
         mode_reg   <= 1'b0;
         start_pend <= AUTO_START;
      end else begin
         done <= 1'b0;

         // Phase lengths are sampled from n_reg/m_reg only at phase entry, so a
         // load here never alters the phase already counting.
         if (load) begin
            n_reg <= (n_in == '0) ? ONE : n_in;
            m_reg <= (m_in == '0) ? ONE : m_in;
         end

         unique case (state)
            IDLE: begin
               if (stop) begin
                  start_pend <= 1'b0;
               end else if (start || start_pend) begin
                  state      <= HIGH;
                  out        <= 1'b1;
                  busy       <= 1'b1;
                  count      <= n_reg;
                  start_pend <= 1'b0;
                  mode_reg   <= start ? mode : 1'b0;
               end
            end

            HIGH: begin
               if (stop) stop_pend <= 1'b1;
               if (count != ONE) begin
                  count <= count - ONE;
               end else begin
                  state <= LOW;
                  out   <= 1'b0;
                  count <= m_reg;
               end
            end

            LOW: begin
               if (stop) stop_pend <= 1'b1;
               if (count != ONE) begin
                  count <= count - ONE;
               end else if (!mode_reg && !stop_pend) begin
                  state <= HIGH;
                  out   <= 1'b1;
                  count <= n_reg;
               end else begin
                  // End of run clears any stop that arrived in this final cycle too.
                  state     <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  stop_pend <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               out   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
